// File: rtl/equiv_scoreboard.sv
// -----------------------------------------------------------------------------
// EquivScoreboard (module equiv_scoreboard)
//
// Compares, transfer by transfer, the outputs of a behavioral model (b_out)
// against those of a structural model (s_out) over a run of NUM_VECTORS
// accepted sample pairs. It tallies accepted pairs and mismatching pairs and
// remembers where the first mismatch happened and which bits differed there.
//
// Parameters
//   WIDTH        bits per compared output vector (W,V,G,H order, MSB = W)
//   NUM_VECTORS  accepted transfers per run, legal range 1..255
//
// Ports
//   clk              in   sole clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   start            in   one-cycle pulse that begins a run
//   in_valid         in   b_out/s_out hold a sample pair
//   in_ready         out  a pair is accepted this cycle (RUN state)
//   b_out            in   behavioral model outputs [WIDTH]
//   s_out            in   structural model outputs [WIDTH]
//   vec_cnt          out  accepted transfers in the current run [8]
//   mismatch_cnt     out  mismatching transfers, saturating at 255 [8]
//   first_fail_idx   out  0-based transfer index of the first mismatch [8]
//   first_fail_diff  out  b_out ^ s_out at the first mismatch [WIDTH]
//   done             out  run complete, results stable
//   pass             out  done with zero mismatches
//
// Build option
//   SCOREBOARD_STOP_ON_FAIL_EN  when defined, the first mismatching transfer
//                               ends the run (DONE on the next cycle).
// -----------------------------------------------------------------------------
module equiv_scoreboard #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] s_out,
  output logic [7:0]       vec_cnt,
  output logic [7:0]       mismatch_cnt,
  output logic [7:0]       first_fail_idx,
  output logic [WIDTH-1:0] first_fail_diff,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  // Transfer count at which a full run is complete.
  localparam logic [7:0] LastCnt = 8'(NUM_VECTORS);

  stateT            state_q, state_d;
  logic [7:0]       vecCnt_q, vecCnt_d;
  logic [7:0]       mismatchCnt_q, mismatchCnt_d;
  logic [7:0]       firstIdx_q, firstIdx_d;
  logic [WIDTH-1:0] firstDiff_q, firstDiff_d;
  logic             firstSeen_q, firstSeen_d;

  logic [WIDTH-1:0] diff;
  logic [7:0]       nextCnt;

  // Bits where the two models disagree, and the count this transfer would
  // produce; both are only consumed when a pair is actually accepted.
  assign diff    = b_out ^ s_out;
  assign nextCnt = vecCnt_q + 8'd1;

  // State and result registers. Reset is asynchronous so the scoreboard
  // drops any partial run the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vecCnt_q      <= 8'd0;
      mismatchCnt_q <= 8'd0;
      firstIdx_q    <= 8'd0;
      firstDiff_q   <= '0;
      firstSeen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vecCnt_q      <= vecCnt_d;
      mismatchCnt_q <= mismatchCnt_d;
      firstIdx_q    <= firstIdx_d;
      firstDiff_q   <= firstDiff_d;
      firstSeen_q   <= firstSeen_d;
    end
  end

  // Next-state and result update. Everything holds by default; only a start
  // pulse outside RUN or an accepted pair inside RUN changes anything.
  // A start in IDLE/DONE takes priority over in_valid, so a pair presented
  // in the same cycle as start is never counted.
  always_comb begin
    state_d       = state_q;
    vecCnt_d      = vecCnt_q;
    mismatchCnt_d = mismatchCnt_q;
    firstIdx_d    = firstIdx_q;
    firstDiff_d   = firstDiff_q;
    firstSeen_d   = firstSeen_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RUN;
          vecCnt_d      = 8'd0;
          mismatchCnt_d = 8'd0;
          firstIdx_d    = 8'd0;
          firstDiff_d   = '0;
          firstSeen_d   = 1'b0;
        end
      end

      RUN: begin
        if (in_valid) begin
          vecCnt_d = nextCnt;
          if (diff != '0) begin
            if (mismatchCnt_q != 8'hFF) begin
              mismatchCnt_d = mismatchCnt_q + 8'd1;
            end
            // Only the first mismatch of a run is recorded; the index is
            // the count before this transfer, i.e. its 0-based position.
            if (!firstSeen_q) begin
              firstSeen_d = 1'b1;
              firstIdx_d  = vecCnt_q;
              firstDiff_d = diff;
            end
          end
          if (nextCnt == LastCnt) begin
            state_d = DONE;
          end
`ifdef SCOREBOARD_STOP_ON_FAIL_EN
          // Early termination: any mismatch ends the run right away.
          if (diff != '0) begin
            state_d = DONE;
          end
`else
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs come straight from registered state, so they follow
  // reset immediately and change one cycle after the deciding transfer.
  always_comb begin
    in_ready        = 1'b0;
    done            = 1'b0;
    pass            = 1'b0;
    vec_cnt         = vecCnt_q;
    mismatch_cnt    = mismatchCnt_q;
    first_fail_idx  = firstIdx_q;
    first_fail_diff = firstDiff_q;
    if (state_q == RUN) begin
      in_ready = 1'b1;
    end
    if (state_q == DONE) begin
      done = 1'b1;
      pass = (mismatchCnt_q == 8'd0);
    end
  end

endmodule

// File: tb/tb_equiv_scoreboard.sv
// -----------------------------------------------------------------------------
// Testbench for equiv_scoreboard. A short table of single-cycle vectors
// covers idle behaviour, start/in_valid collisions, stalls and the first
// mismatch capture; hand-written sequences then cover full runs, alternate
// stalls, reset mid-run, restart from DONE and a 255-vector saturation run on
// a second instance.
// -----------------------------------------------------------------------------
module tb_equiv_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       start, in_valid;
  logic [3:0] b_out, s_out;
  logic       in_ready, done, pass;
  logic [7:0] vec_cnt, mismatch_cnt, first_fail_idx;
  logic [3:0] first_fail_diff;

  logic       start2, inValid2;
  logic [3:0] b2, s2;
  logic       ready2, done2, pass2;
  logic [7:0] vecCnt2, misCnt2, failIdx2;
  logic [3:0] failDiff2;

  int checks;
  int failures;

  typedef struct {
    logic       start;
    logic       inValid;
    logic [3:0] b;
    logic [3:0] s;
    logic       expReady;
    logic       expDone;
    logic       expPass;
    logic [7:0] expVec;
    logic [7:0] expMis;
    logic [7:0] expIdx;
    logic [3:0] expDiff;
  } vecT;

  vecT vecTable [8];

  equiv_scoreboard #(.WIDTH(4), .NUM_VECTORS(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .b_out(b_out), .s_out(s_out),
    .vec_cnt(vec_cnt), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_diff(first_fail_diff),
    .done(done), .pass(pass)
  );

  equiv_scoreboard #(.WIDTH(4), .NUM_VECTORS(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(inValid2),
    .in_ready(ready2), .b_out(b2), .s_out(s2),
    .vec_cnt(vecCnt2), .mismatch_cnt(misCnt2),
    .first_fail_idx(failIdx2), .first_fail_diff(failDiff2),
    .done(done2), .pass(pass2)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison; X/Z on the DUT side counts as a failure.
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compares every output of the 20-vector instance.
  task automatic checkOutput(input string tag, input logic r, input logic d, input logic p,
                             input logic [7:0] vc, input logic [7:0] mc,
                             input logic [7:0] fi, input logic [3:0] fd);
    checkVal({tag, ".in_ready"}, 32'(in_ready), 32'(r));
    checkVal({tag, ".done"}, 32'(done), 32'(d));
    checkVal({tag, ".pass"}, 32'(pass), 32'(p));
    checkVal({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(vc));
    checkVal({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(mc));
    checkVal({tag, ".first_fail_idx"}, 32'(first_fail_idx), 32'(fi));
    checkVal({tag, ".first_fail_diff"}, 32'(first_fail_diff), 32'(fd));
  endtask

  // Drives one cycle of inputs from a falling edge through the next falling
  // edge, then drops the pulse-type inputs.
  task automatic applyStimulus(input logic st, input logic iv, input logic [3:0] b, input logic [3:0] s);
    start    = st;
    in_valid = iv;
    b_out    = b;
    s_out    = s;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Asserts reset part-way through a cycle and checks both instances clear
  // without waiting for a clock edge.
  task automatic pulseReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(tag, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);
    checkVal({tag, ".dut255.ready"}, 32'(ready2), 32'd0);
    checkVal({tag, ".dut255.vec_cnt"}, 32'(vecCnt2), 32'd0);
    checkVal({tag, ".dut255.mismatch_cnt"}, 32'(misCnt2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    b_out    = 4'h0;
    s_out    = 4'h0;
    start2   = 1'b0;
    inValid2 = 1'b0;
    b2       = 4'h0;
    s2       = 4'h0;

    // Fields: start, inValid, b, s | ready, done, pass, vec, mis, idx, diff
    vecTable[0] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0};
    vecTable[1] = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0};
    vecTable[2] = '{1'b0, 1'b1, 4'h3, 4'h3, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 4'h0};
    vecTable[3] = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 4'h0};
    vecTable[4] = '{1'b0, 1'b1, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 8'd0, 4'h0};
    vecTable[5] = '{1'b1, 1'b1, 4'h7, 4'h7, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 8'd0, 4'h0};
`ifdef SCOREBOARD_STOP_ON_FAIL_EN
    vecTable[6] = '{1'b0, 1'b1, 4'hA, 4'h8, 1'b0, 1'b1, 1'b0, 8'd4, 8'd1, 8'd3, 4'h2};
    vecTable[7] = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'd4, 8'd1, 8'd3, 4'h2};
`else
    vecTable[6] = '{1'b0, 1'b1, 4'hA, 4'h8, 1'b1, 1'b0, 1'b0, 8'd4, 8'd1, 8'd3, 4'h2};
    vecTable[7] = '{1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 8'd5, 8'd2, 8'd3, 4'h2};
`endif

    // Reset state, sampled while rst_n is still low.
    #3;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecTable[i].start, vecTable[i].inValid, vecTable[i].b, vecTable[i].s);
      checkOutput($sformatf("vec%0d", i), vecTable[i].expReady, vecTable[i].expDone,
                  vecTable[i].expPass, vecTable[i].expVec, vecTable[i].expMis,
                  vecTable[i].expIdx, vecTable[i].expDiff);
    end

    // Clean 20-vector run from reset.
    pulseReset("rstA");
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("cleanStart", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      logic [3:0] v;
      v = 4'(k);
      applyStimulus(1'b0, 1'b1, v, v);
      if (k == 18) checkOutput("clean19", 1'b1, 1'b0, 1'b0, 8'd19, 8'd0, 8'd0, 4'h0);
    end
    checkOutput("cleanDone", 1'b0, 1'b1, 1'b1, 8'd20, 8'd0, 8'd0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'h0);
    checkOutput("cleanHold", 1'b0, 1'b1, 1'b1, 8'd20, 8'd0, 8'd0, 4'h0);

    // Restart from DONE with in_valid high: results clear, pair not taken.
    applyStimulus(1'b1, 1'b1, 4'h1, 4'h0);
    checkOutput("restart", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);

    // Two mismatches at transfers 5 and 12.
    for (int k = 0; k < 20; k++) begin
      logic [3:0] b, s;
      b = 4'(k);
      s = 4'(k);
      if (k == 5) begin b = 4'hA; s = 4'h8; end
      if (k == 12) begin b = 4'h1; s = 4'h0; end
      applyStimulus(1'b0, 1'b1, b, s);
`ifdef SCOREBOARD_STOP_ON_FAIL_EN
      if (k == 5) begin
        checkOutput("stopAt5", 1'b0, 1'b1, 1'b0, 8'd6, 8'd1, 8'd5, 4'h2);
        break;
      end
`else
      if (k == 5) checkOutput("mis5", 1'b1, 1'b0, 1'b0, 8'd6, 8'd1, 8'd5, 4'h2);
      if (k == 12) checkOutput("mis12", 1'b1, 1'b0, 1'b0, 8'd13, 8'd2, 8'd5, 4'h2);
`endif
    end
`ifdef SCOREBOARD_STOP_ON_FAIL_EN
    applyStimulus(1'b0, 1'b1, 4'h3, 4'h0);
    checkOutput("misFinal", 1'b0, 1'b1, 1'b0, 8'd6, 8'd1, 8'd5, 4'h2);
`else
    checkOutput("misFinal", 1'b0, 1'b1, 1'b0, 8'd20, 8'd2, 8'd5, 4'h2);
`endif

    // Alternate stalls, with start pulses during RUN that must be ignored.
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("altStart", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);
    for (int c = 0; c < 40; c++) begin
      logic iv, st;
      logic [3:0] v;
      iv = ((c % 2) == 0);
      st = (c == 7) || (c == 10);
      v  = 4'(c);
      applyStimulus(st, iv, v, v);
      checkVal($sformatf("alt%0d.vec_cnt", c), 32'(vec_cnt), 32'((c / 2) + 1));
      checkVal($sformatf("alt%0d.done", c), 32'(done), (c >= 38) ? 32'd1 : 32'd0);
    end
    checkOutput("altDone", 1'b0, 1'b1, 1'b1, 8'd20, 8'd0, 8'd0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("altRestart", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);

    // Seven transfers (last one mismatching), then reset mid-run.
    for (int k = 0; k < 7; k++) begin
      logic [3:0] v;
      v = 4'(k + 3);
      applyStimulus(1'b0, 1'b1, (k == 6) ? 4'h4 : v, (k == 6) ? 4'h0 : v);
    end
    checkVal("part7.vec_cnt", 32'(vec_cnt), 32'd7);
    checkVal("part7.mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    checkVal("part7.first_fail_idx", 32'(first_fail_idx), 32'd6);
    checkVal("part7.first_fail_diff", 32'(first_fail_diff), 32'h4);
    pulseReset("rstMid");
    applyStimulus(1'b0, 1'b1, 4'h3, 4'h3);
    checkOutput("postRstIdle", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
    checkOutput("postRstStart", 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'h6, 4'h6);
    checkOutput("postRstXfer", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 4'h0);

    // 255-vector instance, every pair differs in all four bits.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checkVal("big.ready", 32'(ready2), 32'd1);
    for (int k = 0; k < 255; k++) begin
      inValid2 = 1'b1;
      b2 = 4'(k);
      s2 = ~(4'(k));
      @(negedge clk);
`ifndef SCOREBOARD_STOP_ON_FAIL_EN
      if (k == 253) begin
        checkVal("big254.mismatch_cnt", 32'(misCnt2), 32'd254);
        checkVal("big254.done", 32'(done2), 32'd0);
      end
`endif
    end
    inValid2 = 1'b0;
`ifdef SCOREBOARD_STOP_ON_FAIL_EN
    checkVal("big.vec_cnt", 32'(vecCnt2), 32'd1);
    checkVal("big.mismatch_cnt", 32'(misCnt2), 32'd1);
`else
    checkVal("big.vec_cnt", 32'(vecCnt2), 32'd255);
    checkVal("big.mismatch_cnt", 32'(misCnt2), 32'd255);
`endif
    checkVal("big.first_fail_idx", 32'(failIdx2), 32'd0);
    checkVal("big.first_fail_diff", 32'(failDiff2), 32'hF);
    checkVal("big.done", 32'(done2), 32'd1);
    checkVal("big.pass", 32'(pass2), 32'd0);
    checkVal("big.ready_off", 32'(ready2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
